// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types and helpers for the unified memory arbiter.
// Optional fetch buffer in the top is controlled by UNIFIED_MEM_ARB_IBUF_EN.
package unified_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DACC = 2'd1,
        ST_FACC = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Fill bit for read data returned by an access that timed out.
    localparam logic TIMEOUT_FILL = 1'b0;

    function automatic int wait_w(input int max_wait);
        return $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/unified_mem_arbiter_wait_timer.sv
// Wait-cycle counter for the arbiter: cleared between accesses, counts cycles without mem_ready.
// expired fires on the wait cycle that brings the count to MAX_WAIT.
module arb_wait_timer
    import unified_mem_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic expired
);

    localparam int W = wait_w(MAX_WAIT);

    logic [W-1:0] count;

    assign expired = inc && (count == W'(MAX_WAIT - 1));

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && !expired) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Single-port memory arbiter: data access then instruction fetch per pipeline cycle, global stall.
// Defining UNIFIED_MEM_ARB_IBUF_EN adds a one-entry fetch buffer that can skip the memory.
//
// state | meaning
// IDLE  | waiting for requests, issues first access on the next edge
// DACC  | data access outstanding on memory
// FACC  | fetch access outstanding on memory
// DONE  | results valid for one cycle, stall released
module unified_mem_arbiter
    import unified_mem_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_valid,
    input  logic          dm_re,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    output logic [DW-1:0] dm_rdata,
    output logic          dm_valid,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          stall,
    output logic          err
);

    arb_state_e state;
    logic       dm_done;
    logic       acc_busy;
    logic       ready_ok;
    logic       timer_clear;
    logic       timer_inc;
    logic       timer_expired;

`ifdef UNIFIED_MEM_ARB_IBUF_EN
    logic          ibuf_valid;
    logic [AW-1:0] ibuf_tag;
    logic [DW-1:0] ibuf_data;
    logic          ibuf_hit;

    assign ibuf_hit = ibuf_valid && (ibuf_tag == if_addr);
`endif

    assign acc_busy    = (state == ST_DACC) || (state == ST_FACC);
    assign ready_ok    = mem_ready && mem_req;
    assign timer_clear = !acc_busy || ready_ok;
    assign timer_inc   = acc_busy && !ready_ok;
    assign stall       = (dm_re || dm_we || if_req) && (state != ST_DONE);

    arb_wait_timer #(
        .MAX_WAIT(MAX_WAIT)
    ) u_wait_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .inc    (timer_inc),
        .expired(timer_expired)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ST_IDLE;
            dm_done   <= 1'b0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            dm_rdata  <= '0;
            dm_valid  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
`ifdef UNIFIED_MEM_ARB_IBUF_EN
            ibuf_valid <= 1'b0;
            ibuf_tag   <= '0;
            ibuf_data  <= '0;
`endif
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    dm_done <= 1'b0;
                    if (dm_re || dm_we) begin
                        state     <= ST_DACC;
                        mem_req   <= 1'b1;
                        mem_we    <= dm_we;
                        mem_addr  <= dm_addr;
                        mem_wdata <= dm_wdata;
`ifdef UNIFIED_MEM_ARB_IBUF_EN
                        if (dm_we && (dm_addr == ibuf_tag)) begin
                            ibuf_valid <= 1'b0;
                        end
`endif
                    end else if (if_req) begin
`ifdef UNIFIED_MEM_ARB_IBUF_EN
                        if (ibuf_hit) begin
                            state    <= ST_DONE;
                            if_rdata <= ibuf_data;
                            if_valid <= 1'b1;
                        end else begin
                            state    <= ST_FACC;
                            mem_req  <= 1'b1;
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                        end
`else
                        state    <= ST_FACC;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= if_addr;
`endif
                    end
                end
                ST_DACC: begin
                    if (ready_ok) begin
                        if (!mem_we) begin
                            dm_rdata <= mem_rdata;
                        end
                        if (if_req) begin
                            // Fetch issues straight off the data completion edge.
                            state    <= ST_FACC;
                            mem_we   <= 1'b0;
                            mem_addr <= if_addr;
                            dm_done  <= 1'b1;
                        end else begin
                            state    <= ST_DONE;
                            mem_req  <= 1'b0;
                            mem_we   <= 1'b0;
                            dm_valid <= 1'b1;
                        end
                    end else if (timer_expired) begin
                        err <= 1'b1;
                        if (!mem_we) begin
                            dm_rdata <= {DW{TIMEOUT_FILL}};
                        end
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        dm_valid <= 1'b1;
                    end
                end
                ST_FACC: begin
                    if (ready_ok) begin
                        if_rdata <= mem_rdata;
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        dm_valid <= dm_done;
`ifdef UNIFIED_MEM_ARB_IBUF_EN
                        ibuf_valid <= 1'b1;
                        ibuf_tag   <= mem_addr;
                        ibuf_data  <= mem_rdata;
`endif
                    end else if (timer_expired) begin
                        err      <= 1'b1;
                        if_rdata <= {DW{TIMEOUT_FILL}};
                        state    <= ST_DONE;
                        mem_req  <= 1'b0;
                        if_valid <= 1'b1;
                        dm_valid <= dm_done;
                    end
                end
                ST_DONE: begin
                    state   <= ST_IDLE;
                    dm_done <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
